// File: rtl/fifo_pkg.sv
// Shared constants and elaboration-time helpers for the parametrised UART FIFO.
package fifo_pkg;

    localparam bit TMR_OFF    = 1'b0;
    localparam bit TMR_ON     = 1'b1;
    localparam int TMR_COPIES = 3;

    localparam int STICKY_UNDER = 0;
    localparam int STICKY_OVER  = 1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    function automatic bit width_legal(input int width);
        return (width >= 1) && (width <= 32);
    endfunction

    function automatic bit depth_legal(input int depth);
        return (depth >= 4) && (depth <= 65536) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/tmr_vote.sv
// Bitwise 2-of-3 majority voter used to scrub triplicated control registers.
module tmr_vote #(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] y
);

    assign y = (a & b) | (b & c) | (c & a);

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO for UART buffering with optional FWFT output,
// level flags, sticky error flags and optional triplicated control state.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4096,
    parameter int AW    = clog2(DEPTH),
    parameter bit FWFT  = 1'b0,
    parameter bit TMR   = TMR_ON
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             n_clr_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             n_we_i,
    input  logic             n_re_i,
    input  logic [AW:0]      nf_level_i,
    input  logic [AW:0]      ne_level_i,
    output logic [WIDTH-1:0] data_o,
    output logic [AW:0]      count_o,
    output logic             p_empty_o,
    output logic             p_full_o,
    output logic             p_nearfull_o,
    output logic             p_nearempty_o,
    output logic             p_over_o,
    output logic             p_under_o
);

    localparam int PW     = AW + 1;
    localparam int COPIES = (TMR == TMR_ON) ? TMR_COPIES : 1;

    if (!width_legal(WIDTH) || !depth_legal(DEPTH) || (AW != clog2(DEPTH))) begin : g_bad_params
        $error("fifo_sync_param: illegal WIDTH/DEPTH/AW combination");
    end

    logic [COPIES-1:0][PW-1:0] wr_ptr_q;
    logic [COPIES-1:0][PW-1:0] rd_ptr_q;
    logic [COPIES-1:0][1:0]    sticky_q;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [1:0]    sticky;

    logic [PW-1:0] count;
    logic [PW-1:0] count_nxt;
    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] rd_ptr_nxt;
    logic [1:0]    sticky_nxt;
    logic          empty;
    logic          full;
    logic          wr_acc;
    logic          rd_acc;
    logic          head_bypass;

    logic [WIDTH-1:0] mem [DEPTH];

    // Downstream logic only ever sees the voted view of the control state.
    if (COPIES == TMR_COPIES) begin : g_tmr
        tmr_vote #(.W(PW)) u_vote_wr (
            .a (wr_ptr_q[0]),
            .b (wr_ptr_q[1]),
            .c (wr_ptr_q[2]),
            .y (wr_ptr)
        );
        tmr_vote #(.W(PW)) u_vote_rd (
            .a (rd_ptr_q[0]),
            .b (rd_ptr_q[1]),
            .c (rd_ptr_q[2]),
            .y (rd_ptr)
        );
        tmr_vote #(.W(2)) u_vote_sticky (
            .a (sticky_q[0]),
            .b (sticky_q[1]),
            .c (sticky_q[2]),
            .y (sticky)
        );
    end else begin : g_single
        assign wr_ptr = wr_ptr_q[0];
        assign rd_ptr = rd_ptr_q[0];
        assign sticky = sticky_q[0];
    end

    always_comb begin
        count       = wr_ptr - rd_ptr;
        empty       = (count == '0);
        full        = (count == PW'(DEPTH));
        rd_acc      = !n_re_i && !empty;
        wr_acc      = !n_we_i && (!full || rd_acc);
        wr_ptr_nxt  = wr_ptr + PW'(wr_acc);
        rd_ptr_nxt  = rd_ptr + PW'(rd_acc);
        count_nxt   = wr_ptr_nxt - rd_ptr_nxt;
        head_bypass = wr_acc && (rd_ptr_nxt == wr_ptr);
        sticky_nxt  = sticky;
        sticky_nxt[STICKY_OVER]  = sticky[STICKY_OVER]  | (!n_we_i && full && !rd_acc);
        sticky_nxt[STICKY_UNDER] = sticky[STICKY_UNDER] | (!n_re_i && empty);
    end

    // Every copy reloads from the voted next state, so a single upset heals in one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sticky_q <= '0;
        end else if (!n_clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sticky_q <= '0;
        end else begin
            for (int i = 0; i < COPIES; i++) begin
                wr_ptr_q[i] <= wr_ptr_nxt;
                rd_ptr_q[i] <= rd_ptr_nxt;
                sticky_q[i] <= sticky_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_o       <= '0;
            p_empty_o     <= 1'b1;
            p_full_o      <= 1'b0;
            p_nearfull_o  <= 1'b0;
            p_nearempty_o <= 1'b0;
        end else if (!n_clr_i) begin
            count_o       <= '0;
            p_empty_o     <= 1'b1;
            p_full_o      <= 1'b0;
            p_nearfull_o  <= 1'b0;
            p_nearempty_o <= 1'b0;
        end else begin
            count_o       <= count_nxt;
            p_empty_o     <= (count_nxt == '0);
            p_full_o      <= (count_nxt == PW'(DEPTH));
            p_nearfull_o  <= (count_nxt >= nf_level_i);
            p_nearempty_o <= (count_nxt <= ne_level_i);
        end
    end

    assign p_over_o  = sticky[STICKY_OVER];
    assign p_under_o = sticky[STICKY_UNDER];

    always_ff @(posedge clk) begin
        if (wr_acc && n_clr_i) begin
            mem[wr_ptr[AW-1:0]] <= data_i;
        end
    end

    // In FWFT mode a word written into an empty slot is forwarded straight from data_i.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_o <= '0;
        end else if (!n_clr_i) begin
            data_o <= '0;
        end else if (FWFT) begin
            if (count_nxt != '0) begin
                data_o <= head_bypass ? data_i : mem[rd_ptr_nxt[AW-1:0]];
            end
        end else if (rd_acc) begin
            data_o <= mem[rd_ptr[AW-1:0]];
        end
    end

endmodule
